// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcodes and default width for the ALU datapath slices.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   ALU_W  = 8;
endpackage

`default_nettype wire

// File: rtl/add_sub_cell.sv
// ============================================================================
// Module : add_sub_cell
// Brief  : 1-bit combinational full adder / full subtractor cell.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module add_sub_cell
  import alu_pkg::*;
(
  input  logic op,
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic co,
  output logic s
);

  logic w_x_eff;

  // Borrow majority is the carry majority with the minuend bit inverted.
  assign w_x_eff = (op == OP_SUB) ? ~x : x;
  assign s       = x ^ y ^ ci;
  assign co      = (w_x_eff & y) | (w_x_eff & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/add_sub_slice.sv
// ============================================================================
// Module : add_sub_slice
// Brief  : Registered W-bit ripple add/subtract unit with carry and status flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module add_sub_slice
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  logic [W:0]   w_c;
  logic [W-1:0] w_sum;
  logic         w_b_msb_eff;
  logic         w_ovf;

  logic         r_out_valid;
  logic [W-1:0] r_result;
  logic         r_cout;
  logic         r_ovf;
  logic         r_zero;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    add_sub_cell u_cell (
      .op (op),
      .x  (a[i]),
      .y  (b[i]),
      .ci (w_c[i]),
      .co (w_c[i+1]),
      .s  (w_sum[i])
    );
  end

  // Subtract overflows when operand signs differ, add when they match.
  assign w_b_msb_eff = (op == OP_SUB) ? ~b[W-1] : b[W-1];
  assign w_ovf       = (a[W-1] == w_b_msb_eff) && (w_sum[W-1] != a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_sum;
        r_cout   <= w_c[W];
        r_ovf    <= w_ovf;
        r_zero   <= (w_sum == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_slice.sv
// ============================================================================
// Module : tb_add_sub_slice
// Brief  : Scoreboard bench for add_sub_slice at W=8 and W=1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_add_sub_slice;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, op, cin;
  logic [7:0] a, b;
  logic       out_valid, cout, ovf, zero;
  logic [7:0] result;

  logic       v1, op1, cin1, ov1_valid, co1, ovf1, z1;
  logic [0:0] a1, b1, r1;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add_sub_slice #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .result(result), .cout(cout),
    .ovf(ovf), .zero(zero)
  );

  add_sub_slice #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .op(op1), .a(a1), .b(b1),
    .cin(cin1), .out_valid(ov1_valid), .result(r1), .cout(co1),
    .ovf(ovf1), .zero(z1)
  );

  // Independent arithmetic model: integer sums plus a signed range check.
  function automatic exp_t model(int w, logic o, logic [7:0] x, logic [7:0] y, logic c);
    exp_t   e;
    longint ux, uy, uc, m, h, r, sx, sy, t;
    ux = longint'(x);
    uy = longint'(y);
    uc = longint'(c);
    m  = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    if (o == OP_ADD) begin
      r    = ux + uy + uc;
      e.co = ((r >> w) & 1) != 0;
    end else begin
      r    = ux - uy - uc;
      e.co = ux < (uy + uc);
    end
    e.res = 8'(r & m);
    e.z   = (r & m) == 0;
    sx = (ux >= h) ? ux - 2 * h : ux;
    sy = (uy >= h) ? uy - 2 * h : uy;
    t  = (o == OP_ADD) ? sx + sy + uc : sx - sy - uc;
    e.ov = (t > h - 1) || (t < -h);
    return e;
  endfunction

  task automatic apply8(logic o, logic [7:0] x, logic [7:0] y, logic c);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; cin = c;
    exp_q.push_back(model(8, o, x, y, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({out_valid, result, cout, ovf, zero} !== 12'h000) begin
      n_err++;
      $display("FAIL reset8: got %b required 0", {out_valid, result, cout, ovf, zero});
    end
    n_cmp++;
    if ({ov1_valid, r1, co1, ovf1, z1} !== 5'b0) begin
      n_err++;
      $display("FAIL reset1: got %b required 0", {ov1_valid, r1, co1, ovf1, z1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic       to[6];
    logic [7:0] ta[6];
    logic [7:0] tb_[6];
    logic       tc[6];
    exp_t       e;
    to  = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
    ta  = '{8'hFF, 8'h7F, 8'h3C, 8'h00, 8'h80, 8'h05};
    tb_ = '{8'h01, 8'h01, 8'h0A, 8'h01, 8'h01, 8'h05};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply8(to[i], ta[i], tb_[i], tc[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL arith%0d out_valid: got %b required 1", i, out_valid);
      end
      n_cmp++;
      if ({result, cout, ovf, zero} !== {e.res, e.co, e.ov, e.z}) begin
        n_err++;
        $display("FAIL arith%0d res/co/ov/z: got %h/%b/%b/%b required %h/%b/%b/%b",
                 i, result, cout, ovf, zero, e.res, e.co, e.ov, e.z);
      end
    end
  endtask

  task automatic test_hold();
    apply8(OP_ADD, 8'h3C, 8'h0A, 1'b1);
    last_exp = exp_q.pop_front();
    n_cmp++;
    if (result !== 8'h47) begin
      n_err++;
      $display("FAIL hold_setup: got %h required 47", result);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1; op = OP_SUB;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold%0d out_valid: got %b required 0", i, out_valid);
      end
      n_cmp++;
      if ({result, cout, ovf, zero} !== {last_exp.res, last_exp.co, last_exp.ov, last_exp.z}) begin
        n_err++;
        $display("FAIL hold%0d outputs: got %h/%b/%b/%b required %h/%b/%b/%b", i,
                 result, cout, ovf, zero, last_exp.res, last_exp.co, last_exp.ov, last_exp.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      apply8(1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, result, cout, ovf, zero} !== {1'b1, e.res, e.co, e.ov, e.z}) begin
        n_err++;
        $display("FAIL b2b%0d: got v=%b %h/%b/%b/%b required v=1 %h/%b/%b/%b (op=%b a=%h b=%h cin=%b)",
                 i, out_valid, result, cout, ovf, zero, e.res, e.co, e.ov, e.z, op, a, b, cin);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply8(OP_ADD, 8'hFF, 8'h01, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (zero !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre: got zero=%b v=%b required 1/1", zero, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1; op = OP_SUB; a = 8'h12; b = 8'h34; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, result, cout, ovf, zero} !== 12'h000) begin
      n_err++;
      $display("FAIL rmid_async: got %b required 0", {out_valid, result, cout, ovf, zero});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, result, cout, ovf, zero} !== 12'h000) begin
      n_err++;
      $display("FAIL rmid_held: got %b required 0", {out_valid, result, cout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    apply8(OP_SUB, 8'h80, 8'h01, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, e.res, e.co, e.ov, e.z}) begin
      n_err++;
      $display("FAIL rmid_post: got v=%b %h/%b/%b/%b required v=1 %h/%b/%b/%b",
               out_valid, result, cout, ovf, zero, e.res, e.co, e.ov, e.z);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_w1();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v1 = 1'b1; op1 = i[3]; a1 = i[2]; b1 = i[1]; cin1 = i[0];
      exp_q.push_back(model(1, i[3], {7'b0, i[2]}, {7'b0, i[1]}, i[0]));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({ov1_valid, r1, co1, ovf1, z1} !== {1'b1, e.res[0], e.co, e.ov, e.z}) begin
        n_err++;
        $display("FAIL w1_%0d (op=%b a=%b b=%b cin=%b): got v=%b r=%b co=%b ov=%b z=%b required v=1 r=%b co=%b ov=%b z=%b",
                 i, i[3], i[2], i[1], i[0], ov1_valid, r1, co1, ovf1, z1, e.res[0], e.co, e.ov, e.z);
      end
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; op = OP_ADD; a = '0; b = '0; cin = 1'b0;
    v1 = 1'b0; op1 = OP_ADD; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_arith();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_w1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
